cla_adder: RTL and testbench

CLA_ADDER -- requirements
Module: cla_adder

---
 rtl/cla_pkg.sv | 11 +
 rtl/cla_block4.sv | 32 +++
 rtl/cla_adder.sv | 76 +++++++
 tb/tb_cla_adder.sv | 131 +++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared constants and width check for the carry-lookahead adder
package cla_pkg;

    localparam int unsigned CLA_GROUP = 4;

    // True when a requested adder width splits evenly into lookahead groups
    function automatic bit cla_width_ok(input int unsigned width);
        return (width % CLA_GROUP == 0) && (width >= CLA_GROUP) && (width <= 64);
    endfunction

endpackage

// File: rtl/cla_block4.sv
// rtl/cla_block4.sv - 4-bit carry-lookahead group with group generate/propagate
module cla_block4
    import cla_pkg::*;
(
    input  logic [CLA_GROUP-1:0] a,
    input  logic [CLA_GROUP-1:0] b,
    input  logic                 cin,
    output logic [CLA_GROUP-1:0] s,
    output logic                 G,
    output logic                 P
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    // Every internal carry is a flat sum of products of g, p and cin
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        s    = p ^ c;
        G    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
        P    = &p;
    end

endmodule

// File: rtl/cla_adder.sv
// rtl/cla_adder.sv - two-level carry-lookahead adder with registered sum and carry
module cla_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int unsigned NG = WIDTH / CLA_GROUP;

    if (!cla_width_ok(WIDTH)) begin : g_bad_width
        $error("cla_adder: WIDTH must be a multiple of 4 between 4 and 64");
    end

    logic [NG-1:0]    grp_g;
    logic [NG-1:0]    grp_p;
    logic [NG:0]      grp_c;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             prod;
    logic             cacc;

    for (genvar k = 0; k < NG; k++) begin : g_grp
        cla_block4 u_blk (
            .a   (in_1[k*CLA_GROUP +: CLA_GROUP]),
            .b   (in_2[k*CLA_GROUP +: CLA_GROUP]),
            .cin (grp_c[k]),
            .s   (sum_d[k*CLA_GROUP +: CLA_GROUP]),
            .G   (grp_g[k]),
            .P   (grp_p[k])
        );
    end

    // Second level: each group carry is an OR of independent product terms,
    // one per possible generating source, so no carry waits on another group
    always_comb begin
        grp_c    = '0;
        prod     = 1'b0;
        cacc     = 1'b0;
        grp_c[0] = carry_in;
        for (int k = 1; k <= NG; k++) begin
            cacc = 1'b0;
            for (int j = 0; j <= k; j++) begin
                prod = (j == 0) ? carry_in : grp_g[j-1];
                for (int m = j; m < k; m++) begin
                    prod = prod & grp_p[m];
                end
                cacc = cacc | prod;
            end
            grp_c[k] = cacc;
        end
    end

    // Output register: one-cycle latency, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= grp_c[NG];
        end
    end

    assign sum       = sum_q;
    assign carry_out = carry_q;

endmodule

// File: tb/tb_cla_adder.sv
// tb/tb_cla_adder.sv - self-checking bench for cla_adder at widths 8, 16 and 32
module tb_cla_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;

    logic [7:0]  s8;
    logic        co8;
    logic [15:0] s16;
    logic        co16;
    logic [31:0] s32;
    logic        co32;

    int checks   = 0;
    int failures = 0;

    logic [8:0]  e8;
    logic [16:0] e16;
    logic [32:0] e32;
    bit          model_ok = 1'b0;

    always #5 clk = ~clk;

    cla_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_1(a[7:0]), .in_2(b[7:0]), .carry_in(cin),
        .sum(s8), .carry_out(co8)
    );

    cla_adder #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_1(a[15:0]), .in_2(b[15:0]), .carry_in(cin),
        .sum(s16), .carry_out(co16)
    );

    cla_adder #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .in_1(a), .in_2(b), .carry_in(cin),
        .sum(s32), .carry_out(co32)
    );

    task automatic check(input string name, input logic [32:0] got, input logic [32:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference: what each adder must show after this edge, from plain arithmetic
    always @(posedge clk) begin
        if (rst) begin
            e8  = '0;
            e16 = '0;
            e32 = '0;
        end else begin
            e8  = 9'(a[7:0])   + 9'(b[7:0])   + 9'(cin);
            e16 = 17'(a[15:0]) + 17'(b[15:0]) + 17'(cin);
            e32 = 33'(a)       + 33'(b)       + 33'(cin);
        end
        model_ok = 1'b1;
    end

    // Compare every DUT against the reference on each falling edge
    always @(negedge clk) begin
        if (model_ok) begin
            check("model_w8",  33'({co8, s8}),   33'(e8));
            check("model_w16", 33'({co16, s16}), 33'(e16));
            check("model_w32", {co32, s32},      e32);
        end
    end

    task automatic apply(input logic [31:0] ai, input logic [31:0] bi, input logic ci);
        a   = ai;
        b   = bi;
        cin = ci;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        a   = 32'h0000_00FF;
        b   = 32'h0000_0001;
        cin = 1'b0;

        @(negedge clk);
        check("reset_c1_w8", 33'({co8, s8}), 33'h0);
        @(negedge clk);
        check("reset_c2_w8", 33'({co8, s8}), 33'h0);
        check("reset_c2_w32", {co32, s32}, 33'h0);
        rst = 1'b0;

        apply(32'h0000_00FF, 32'h0000_0000, 1'b1);
        check("full_chain_w8", 33'({co8, s8}), 33'h100);
        check("full_chain_w16", 33'({co16, s16}), 33'h00100);

        apply(32'h0000_0055, 32'h0000_00AA, 1'b0);
        check("no_carry_w8", 33'({co8, s8}), 33'h0FF);

        apply(32'h0000_0080, 32'h0000_0080, 1'b0);
        check("wrap_w8", 33'({co8, s8}), 33'h100);

        apply(32'h0000_000F, 32'h0000_0001, 1'b0);
        check("after_wrap_w8", 33'({co8, s8}), 33'h010);

        apply(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        check("full_chain_w32", {co32, s32}, 33'h1_0000_0000);
        check("full_chain_w16_wrap", 33'({co16, s16}), 33'h10000);

        apply(32'h1234_5678, 32'h0FED_CBA8, 1'b1);
        check("mixed_w32", {co32, s32}, 33'h0_2222_2221);

        for (int i = 0; i < 10000; i++) begin
            rst = (i == 5000);
            apply($urandom, $urandom, 1'($urandom_range(0, 1)));
            if (i == 5000) begin
                check("midrst_w8",  33'({co8, s8}),   33'h0);
                check("midrst_w16", 33'({co16, s16}), 33'h0);
                check("midrst_w32", {co32, s32},      33'h0);
            end
        end
        rst = 1'b0;

        apply(32'h0000_0000, 32'h0000_0000, 1'b0);
        check("zero_w32", {co32, s32}, 33'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
